alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The module SHALL have one parameter, one per line: DW, 32, operand/result width.
REQ-002 Ports SHALL be, one per line (name direction width meaning):
 clk  input  1  single clock; all state changes on rising edge
 reset  input  1  synchronous, active-high reset
 req0_valid / req1_valid  input  1  requester n has an operation pending
 req0_ready / req1_ready  output  1  requester n's operation accepted this cycle
 req0_op / req1_op  input  2  ALU opcode from requester n
 req0_ff / req1_ff  input  1  opcode bit 9 of requester n
 req0_a, req0_b / req1_a, req1_b  input  DW  operands of requester n
 resp0_valid / resp1_valid  output  1  result ready for requester n
 resp0_ready / resp1_ready  input  1  requester n consumes result
 resp_data  output  DW  registered result
 resp_nzco  output  4  registered flags {N,Z,C,O}
 alu_op  output  2  final opcode to shared ALU
 alu_in1, alu_in2  output  DW  operands to shared ALU
 alu_res  input  DW  shared ALU result
 alu_nzco  input  4  shared ALU flags {N,Z,C,O}
REQ-003 Clock SHALL be named clk and reset SHALL be named reset; one clock, reset synchronous and active-high.

Function
REQ-004 FSM SHALL have states IDLE, EXEC, DONE.
REQ-005 In IDLE, reqN_ready SHALL be 1 only for the granted requester, and only when that requester's reqN_valid is 1; at most one ready per cycle.
REQ-006 Handshake SHALL complete when reqN_valid & reqN_ready; op, ff, a, b SHALL be registered that cycle and FSM SHALL go IDLE->EXEC.
REQ-007 Opcode mapping SHALL be: op 11 with ff=0 -> alu_op 10; op 11 with ff=1 -> alu_op 11; otherwise alu_op = op.
REQ-008 alu_op, alu_in1, alu_in2 SHALL be driven from the registered operands only in EXEC; in all other states alu_op SHALL be 00 and alu_in1/alu_in2 SHALL be 0.
REQ-009 In EXEC, alu_res and alu_nzco SHALL be captured into resp_data/resp_nzco and FSM SHALL go EXEC->DONE unconditionally.
REQ-010 In DONE, respN_valid SHALL be 1 for the owning requester only; it SHALL hold with resp_data/resp_nzco stable until respN_ready=1, then FSM SHALL go DONE->IDLE.
REQ-011 respN_ready for the non-owning requester SHALL be ignored.
REQ-012 Latency SHALL be: accept in cycle T, EXEC in T+1, respN_valid first high in T+2; max throughput one operation per 3 cycles.
REQ-013 Arbitration (default) SHALL be round-robin: last_grant register; if both valid, grant the requester not in last_grant; if one valid, grant it; last_grant updates only on accept.
REQ-014 A requester that drops reqN_valid before acceptance SHALL NOT be accepted; no operation is queued.
REQ-015 Flags SHALL be passed through unmodified from the ALU; the module SHALL NOT recompute them.

Reset
REQ-016 On reset=1 at a rising edge: state=IDLE, last_grant=1 (requester 0 wins first tie), resp_data=0, resp_nzco=0, registered operands=0.
REQ-017 While reset is high and the cycle after, all ready/valid outputs SHALL be 0 and alu_op=00.
REQ-018 Reset asserted in EXEC or DONE SHALL abort the operation; its result SHALL never be presented.

Configuration
REQ-019 Macro ALU_ARB_FIXED_PRI_EN: when defined, requester 0 SHALL always win when both valid and last_grant SHALL be removed; when undefined, REQ-013 round-robin applies.

Verification
REQ-020 Only req0 valid, op=01, a=5, b=7 -> req0_ready at T, alu_op=01 at T+1, resp0_valid at T+2 with resp_data=12, nzco=0000.
REQ-021 req1 op=11 ff=0, a=3, b=3 -> alu_op=10, resp_data=0, Z=1; op=11 ff=1, a=1, b=4 -> alu_op=11, resp_data=16.
REQ-022 Both valid continuously after reset, 4 ops -> grants 0,1,0,1 (default); with ALU_ARB_FIXED_PRI_EN -> 0,0,0,0.
REQ-023 resp0_ready held 0 for 5 cycles in DONE, resp1_ready=1 throughout -> resp0_valid and resp_data stable, no req accepted, FSM stays DONE.
REQ-024 reset pulsed in EXEC -> next cycles IDLE, no respN_valid, resp_data=0; following req0 accepted normally.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter
// Arbitrates two requesters onto one shared, external, combinational ALU.
// Only one operation is in flight at a time:
//   IDLE: accept one request.
//   EXEC: drive the ALU and capture its result and flags.
//   DONE: present the result to the owning requester until it consumes it.
//
// Handshake semantics:
//   A request transfers on a cycle where reqN_valid && reqN_ready.
//   A response transfers on a cycle where respN_valid && respN_ready.
//   Valid is never required to wait for ready.
//   Ready is a combinational function of valid, because it carries the
//   grant decision.
//
// Parameters:
//   DW - operand/result width
//
// Ports:
//   clk, reset                 clock; synchronous active-high reset
//   reqN_valid/ready           request handshake for requester N (N = 0, 1)
//   reqN_op, reqN_ff           opcode and opcode bit 9 of requester N
//   reqN_a, reqN_b             operands of requester N
//   respN_valid/ready          response handshake for requester N
//   resp_data, resp_nzco       registered result and flags {N,Z,C,O}
//   alu_op, alu_in1, alu_in2   drive to the shared ALU (zero outside EXEC)
//   alu_res, alu_nzco          result and flags returned by the shared ALU
//
// Configuration:
//   ALU_ARB_FIXED_PRI_EN  when defined, requester 0 always wins a tie and
//                         no last-grant state is kept. The default build
//                         uses round-robin arbitration.
module alu_arbiter #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [1:0]    req0_op,
  input  logic          req0_ff,
  input  logic [DW-1:0] req0_a,
  input  logic [DW-1:0] req0_b,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [1:0]    req1_op,
  input  logic          req1_ff,
  input  logic [DW-1:0] req1_a,
  input  logic [DW-1:0] req1_b,
  output logic          resp0_valid,
  input  logic          resp0_ready,
  output logic          resp1_valid,
  input  logic          resp1_ready,
  output logic [DW-1:0] resp_data,
  output logic [3:0]    resp_nzco,
  output logic [1:0]    alu_op,
  output logic [DW-1:0] alu_in1,
  output logic [DW-1:0] alu_in2,
  input  logic [DW-1:0] alu_res,
  input  logic [3:0]    alu_nzco
);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, DONE = 2'd2} state_t;

  state_t        state, state_nxt;
  logic          owner;      // requester index of the operation in flight
  logic [1:0]    op_q;
  logic          ff_q;
  logic [DW-1:0] a_q, b_q;
  logic          rst_q;      // high for the first cycle after reset releases
  logic          grant;      // requester index that would be accepted now
  logic          can_accept;
  logic          accept;
  logic          resp_take;

`ifdef ALU_ARB_FIXED_PRI_EN
  // Requester 0 wins whenever it is valid.
  always_comb begin
    grant = ~req0_valid;
  end
`else
  logic last_grant;

  // On a tie, the requester that was not granted last wins.
  // Otherwise, the single valid requester wins.
  always_comb begin
    if (req0_valid && req1_valid) grant = ~last_grant;
    else                          grant = ~req0_valid;
  end
`endif

  // Readiness is suppressed while reset is high and on the cycle after it.
  assign can_accept = (state == IDLE) && !reset && !rst_q;
  assign req0_ready = can_accept && req0_valid && !grant;
  assign req1_ready = can_accept && req1_valid && grant;
  assign accept     = req0_ready || req1_ready;

  assign resp0_valid = (state == DONE) && !reset && !owner;
  assign resp1_valid = (state == DONE) && !reset && owner;
  // The ready signal of the requester that does not own the result is ignored.
  assign resp_take   = owner ? resp1_ready : resp0_ready;

  always_comb begin
    state_nxt = state;
    alu_op    = 2'b00;
    alu_in1   = '0;
    alu_in2   = '0;
    case (state)
      IDLE: if (accept) state_nxt = EXEC;
      EXEC: begin
        state_nxt = DONE;
        if (!reset) begin
          // Opcode 11 is split by ff: ff=0 selects ALU op 10, ff=1 keeps 11.
          alu_op  = (op_q == 2'b11) ? {1'b1, ff_q} : op_q;
          alu_in1 = a_q;
          alu_in2 = b_q;
        end
      end
      DONE: if (resp_take) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      owner     <= 1'b0;
      op_q      <= 2'b00;
      ff_q      <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      resp_data <= '0;
      resp_nzco <= 4'b0000;
      rst_q     <= 1'b1;
`ifndef ALU_ARB_FIXED_PRI_EN
      last_grant <= 1'b1;
`endif
    end else begin
      state <= state_nxt;
      rst_q <= 1'b0;
      if (accept) begin
        owner <= grant;
        op_q  <= grant ? req1_op : req0_op;
        ff_q  <= grant ? req1_ff : req0_ff;
        a_q   <= grant ? req1_a  : req0_a;
        b_q   <= grant ? req1_b  : req0_b;
`ifndef ALU_ARB_FIXED_PRI_EN
        last_grant <= grant;
`endif
      end
      if (state == EXEC) begin
        resp_data <= alu_res;
        resp_nzco <= alu_nzco;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0_valid, req1_valid;
  logic          req0_ready, req1_ready;
  logic [1:0]    req0_op, req1_op;
  logic          req0_ff, req1_ff;
  logic [DW-1:0] req0_a, req0_b, req1_a, req1_b;
  logic          resp0_valid, resp1_valid;
  logic          resp0_ready, resp1_ready;
  logic [DW-1:0] resp_data;
  logic [3:0]    resp_nzco;
  logic [1:0]    alu_op;
  logic [DW-1:0] alu_in1, alu_in2;
  logic [DW-1:0] alu_res;
  logic [3:0]    alu_nzco;

  int total = 0;
  int bad   = 0;

  // Clock and DUT instance.
  always #5 clk = ~clk;

  alu_arbiter #(.DW(DW)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_ff(req0_ff), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_ff(req1_ff), .req1_a(req1_a), .req1_b(req1_b),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
    .resp_data(resp_data), .resp_nzco(resp_nzco),
    .alu_op(alu_op), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .alu_res(alu_res), .alu_nzco(alu_nzco)
  );

  // External shared ALU: 00 AND, 01 ADD, 10 SUB, 11 SHL.
  // Flags are {N,Z,C,O}; C is carry for ADD and borrow for SUB.
  always_comb begin
    logic [DW:0] wide;
    logic        c, o;
    wide = '0;
    c    = 1'b0;
    o    = 1'b0;
    case (alu_op)
      2'b00: wide = {1'b0, alu_in1 & alu_in2};
      2'b01: begin
        wide = {1'b0, alu_in1} + {1'b0, alu_in2};
        c    = wide[DW];
        o    = (alu_in1[DW-1] == alu_in2[DW-1]) && (wide[DW-1] != alu_in1[DW-1]);
      end
      2'b10: begin
        wide = {1'b0, alu_in1 - alu_in2};
        c    = alu_in1 < alu_in2;
        o    = (alu_in1[DW-1] != alu_in2[DW-1]) && (wide[DW-1] != alu_in1[DW-1]);
      end
      default: wide = {1'b0, alu_in1 << alu_in2[4:0]};
    endcase
    alu_res  = wide[DW-1:0];
    alu_nzco = {wide[DW-1], (wide[DW-1:0] == '0), c, o};
  end

  // Comparison helper: counts every check and reports each failure.
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one cycle; inputs change and outputs are sampled 1 time unit after
  // the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic sel, input logic [1:0] op, input logic ff,
                           input logic [DW-1:0] a, input logic [DW-1:0] b);
    if (!sel) begin
      req0_valid = 1'b1; req0_op = op; req0_ff = ff; req0_a = a; req0_b = b;
    end else begin
      req1_valid = 1'b1; req1_op = op; req1_ff = ff; req1_a = a; req1_b = b;
    end
  endtask

  task automatic idle_inputs();
    req0_valid = 0; req1_valid = 0; req0_op = 0; req1_op = 0;
    req0_ff = 0; req1_ff = 0; req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
    resp0_ready = 0; resp1_ready = 0;
  endtask

  typedef struct {
    logic          sel;
    logic [1:0]    op;
    logic          ff;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [1:0]    exp_op;
    logic [DW-1:0] exp_data;
    logic [3:0]    exp_nzco;
  } vec_t;

  vec_t vecs[7];
  logic [DW-1:0] held;
  int grants[$];
  int exp_g[4];
  int cyc;

  initial begin
    vecs[0] = '{1'b0, 2'b01, 1'b0, 32'd5,          32'd7,      2'b01, 32'd12,         4'b0000};
    vecs[1] = '{1'b1, 2'b11, 1'b0, 32'd3,          32'd3,      2'b10, 32'd0,          4'b0100};
    vecs[2] = '{1'b1, 2'b11, 1'b1, 32'd1,          32'd4,      2'b11, 32'd16,         4'b0000};
    vecs[3] = '{1'b0, 2'b00, 1'b1, 32'h0000_F0F0, 32'h0000_FF00, 2'b00, 32'h0000_F000, 4'b0000};
    vecs[4] = '{1'b1, 2'b10, 1'b1, 32'd2,          32'd5,      2'b10, 32'hFFFF_FFFD,  4'b1010};
    vecs[5] = '{1'b0, 2'b01, 1'b0, 32'hFFFF_FFFF, 32'd1,      2'b01, 32'd0,          4'b0110};
    vecs[6] = '{1'b0, 2'b01, 1'b0, 32'h7FFF_FFFF, 32'd1,      2'b01, 32'h8000_0000,  4'b1001};

    // Reset state, with requests already pending.
    idle_inputs();
    reset = 1'b1;
    drive_req(1'b0, 2'b01, 1'b0, 32'd1, 32'd1);
    tick();
    tick();
    chk("rst_req0_ready", req0_ready, 0);
    chk("rst_resp0_valid", resp0_valid, 0);
    chk("rst_alu_op", alu_op, 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_resp_nzco", resp_nzco, 0);
    reset = 1'b0;
    #1;
    chk("post_rst_req0_ready", req0_ready, 0);
    chk("post_rst_alu_in1", alu_in1, 0);
    req0_valid = 1'b0;
    tick();

    // Table-driven single operations.
    for (int i = 0; i < 7; i++) begin
      drive_req(vecs[i].sel, vecs[i].op, vecs[i].ff, vecs[i].a, vecs[i].b);
      #1;
      chk($sformatf("v%0d_ready", i), vecs[i].sel ? req1_ready : req0_ready, 1);
      chk($sformatf("v%0d_other_ready", i), vecs[i].sel ? req0_ready : req1_ready, 0);
      tick();
      req0_valid = 0;
      req1_valid = 0;
      #1;
      chk($sformatf("v%0d_alu_op", i), alu_op, vecs[i].exp_op);
      chk($sformatf("v%0d_alu_in1", i), alu_in1, vecs[i].a);
      chk($sformatf("v%0d_alu_in2", i), alu_in2, vecs[i].b);
      chk($sformatf("v%0d_early_valid", i), resp0_valid | resp1_valid, 0);
      tick();
      chk($sformatf("v%0d_resp_valid", i), {resp1_valid, resp0_valid},
          vecs[i].sel ? 2'b10 : 2'b01);
      chk($sformatf("v%0d_data", i), resp_data, vecs[i].exp_data);
      chk($sformatf("v%0d_nzco", i), resp_nzco, vecs[i].exp_nzco);
      chk($sformatf("v%0d_done_alu_op", i), alu_op, 0);
      if (vecs[i].sel) resp1_ready = 1; else resp0_ready = 1;
      tick();
      resp0_ready = 0;
      resp1_ready = 0;
      #1;
      chk($sformatf("v%0d_released", i), resp0_valid | resp1_valid, 0);
    end

    // Result held in DONE: the non-owner's ready is ignored and no request is
    // accepted.
    drive_req(1'b0, 2'b01, 1'b0, 32'd20, 32'd22);
    tick();
    req0_valid = 0;
    tick();
    held = resp_data;
    chk("hold_first_data", held, 32'd42);
    resp1_ready = 1;
    drive_req(1'b1, 2'b01, 1'b0, 32'd1, 32'd1);
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("hold%0d_valid", k), resp0_valid, 1);
      chk($sformatf("hold%0d_data", k), resp_data, held);
      chk($sformatf("hold%0d_req1_ready", k), req1_ready, 0);
      tick();
    end
    req1_valid = 0;
    resp1_ready = 0;
    resp0_ready = 1;
    tick();
    resp0_ready = 0;
    #1;
    chk("hold_release", resp0_valid, 0);

    // Reset while in EXEC aborts the operation.
    drive_req(1'b0, 2'b01, 1'b0, 32'd9, 32'd9);
    tick();
    chk("abort_in_exec", alu_op, 2'b01);
    reset = 1;
    #1;
    chk("abort_rst_alu_op", alu_op, 0);
    tick();
    reset = 0;
    #1;
    chk("abort_req0_ready_blocked", req0_ready, 0);
    chk("abort_no_resp", resp0_valid | resp1_valid, 0);
    chk("abort_data_zero", resp_data, 0);
    tick();
    chk("abort_still_no_resp", resp0_valid, 0);
    chk("abort_accept_again", req0_ready, 1);
    drive_req(1'b0, 2'b01, 1'b0, 32'd5, 32'd7);
    tick();
    req0_valid = 0;
    tick();
    chk("abort_next_valid", resp0_valid, 1);
    chk("abort_next_data", resp_data, 32'd12);
    resp0_ready = 1;
    tick();
    resp0_ready = 0;

    // Arbitration with both requesters valid continuously after reset.
`ifdef ALU_ARB_FIXED_PRI_EN
    exp_g = '{0, 0, 0, 0};
`else
    exp_g = '{0, 1, 0, 1};
`endif
    reset = 1;
    tick();
    reset = 0;
    drive_req(1'b0, 2'b01, 1'b0, 32'd1, 32'd2);
    drive_req(1'b1, 2'b01, 1'b0, 32'd3, 32'd4);
    resp0_ready = 1;
    resp1_ready = 1;
    cyc = 0;
    while (grants.size() < 4 && cyc < 40) begin
      #1;
      if (req0_ready && req1_ready) chk("arb_double_ready", 1, 0);
      if (req0_ready) grants.push_back(0);
      else if (req1_ready) grants.push_back(1);
      tick();
      cyc++;
    end
    chk("arb_grant_count", grants.size(), 4);
    for (int g = 0; g < 4 && g < grants.size(); g++)
      chk($sformatf("arb_grant%0d", g), grants[g], exp_g[g]);
    idle_inputs();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
